// File: rtl/timer_control.sv
// timer_control
// Control stage in front of a four-digit BCD down-counter chain. It turns
// start/stop/set button events into count enables, load and clear pulses. It
// also divides the system clock down to the count tick and flags completion
// when the chain reaches 0000.
module timer_control #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       set_btn,
  input  logic [3:0] nz,
  output logic [3:0] en_n,
  output logic [3:0] hi_nz,
  output logic       load,
  output logic       cnt_clr,
  output logic       alarm,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Prescaler spans 0..TICK_DIV-1; at least one bit even for TICK_DIV=2.
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  // en_n is registered, so the tick pattern is armed one cycle before the
  // prescaler reaches its last value. The enable is then low exactly while
  // the prescaler sits at TICK_DIV-1.
  localparam logic [PW-1:0] PRESC_ARM  = PW'(TICK_DIV - 2);

  state_t          state_q;
  logic [PW-1:0]   presc;
  logic            start_prev;
  logic            stop_prev;
  logic            set_prev;
  logic            start_ev;
  logic            stop_ev;
  logic            set_ev;
  logic            any_nz;
  logic [3:0]      tick_en_n;

  assign state  = state_q;
  assign any_nz = |nz;

  // Rising-edge events. The previous-value registers come out of reset at 1,
  // so a button held through reset produces no event.
  assign start_ev = start_btn & ~start_prev;
  assign stop_ev  = stop_btn  & ~stop_prev;
  assign set_ev   = set_btn   & ~set_prev;

  // Borrow qualifier: digit i may borrow from above only if some higher digit
  // is nonzero. The top digit never has anything above it.
  assign hi_nz = {1'b0, nz[3], |nz[3:2], |nz[3:1]};

  // Enable pattern for one count-down step: digit 0 always moves; digit i
  // moves only when every digit below it is zero, so it receives the borrow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    tick_en_n    = 4'b1111;
    tick_en_n[0] = 1'b0;
    tick_en_n[1] = nz[0];
    tick_en_n[2] = |nz[1:0];
    tick_en_n[3] = |nz[2:0];
  end

  // Button history, FSM, prescaler and all registered outputs.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= S_IDLE;
      presc      <= '0;
      en_n       <= 4'b1111;
      load       <= 1'b0;
      cnt_clr    <= 1'b0;
      alarm      <= 1'b0;
      start_prev <= 1'b1;
      stop_prev  <= 1'b1;
      set_prev   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
      start_prev <= start_btn;
      stop_prev  <= stop_btn;
      set_prev   <= set_btn;

      // Pulse outputs fall back to idle unless a branch below raises them.
      en_n    <= 4'b1111;
      load    <= 1'b0;
      cnt_clr <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (set_ev) begin
            load <= 1'b1;
          end else if (stop_ev) begin
            cnt_clr <= 1'b1;
          end else if (start_ev && any_nz) begin
            state_q <= S_RUN;
            presc   <= '0;
          end
        end

        S_RUN: begin
          presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
          // Reaching 0000 outranks a stop request. Set is not accepted while
          // counting.
          if (!any_nz) begin
            state_q <= S_DONE;
            alarm   <= 1'b1;
          end else if (stop_ev) begin
            state_q <= S_PAUSE;
          end else if (presc == PRESC_ARM) begin
            en_n <= tick_en_n;
          end
        end

        S_PAUSE: begin
          // The prescaler holds here and restarts from zero on resume.
          if (set_ev) begin
            load    <= 1'b1;
            state_q <= S_IDLE;
          end else if (stop_ev) begin
            cnt_clr <= 1'b1;
            state_q <= S_IDLE;
          end else if (start_ev && any_nz) begin
            state_q <= S_RUN;
            presc   <= '0;
          end
        end

        S_DONE: begin
          if (set_ev) begin
            load    <= 1'b1;
            state_q <= S_IDLE;
            alarm   <= 1'b0;
          end else if (stop_ev) begin
            state_q <= S_IDLE;
            alarm   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_control.sv
// tb_timer_control
// Directed walk through the timer's control behaviour, followed by a random
// button storm. The bench holds its own copy of the four-digit counter chain
// as a plain integer and drives nz from it. Expected outputs come from a
// reference model written in terms of that integer: a tick enables exactly
// the digits that change when the value counts down by one.
module tb_timer_control;

  localparam int TICK_DIV = 4;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;
  localparam int S_DONE   = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       set_btn = 1'b0;
  logic [3:0] nz = 4'h0;
  logic [3:0] en_n;
  logic [3:0] hi_nz;
  logic       load;
  logic       cnt_clr;
  logic       alarm;
  logic [1:0] state;

  timer_control #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .clear     (clear),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .set_btn   (set_btn),
    .nz        (nz),
    .en_n      (en_n),
    .hi_nz     (hi_nz),
    .load      (load),
    .cnt_clr   (cnt_clr),
    .alarm     (alarm),
    .state     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Counter chain contents (0..9999) and the value a load would copy in.
  int cnt    = 0;
  int preset = 0;

  // Reference model state.
  int         m_state;
  int         m_k;        // index of the current cycle since entering RUN
  logic [3:0] m_en_n;
  bit         m_load;
  bit         m_clr;
  bit         m_alarm;
  bit         m_prev_st;
  bit         m_prev_sp;
  bit         m_prev_se;

  function automatic int digit(input int v, input int i);
    return (v / (10 ** i)) % 10;
  endfunction

  function automatic logic [3:0] nz_of(input int v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (digit(v, i) != 0);
    return r;
  endfunction

  function automatic logic [3:0] exp_hi_nz(input int v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i < 3) && ((v / (10 ** (i + 1))) != 0);
    return r;
  endfunction

  // A digit is enabled on a tick exactly when counting v down by one changes it.
  function automatic logic [3:0] exp_en_n(input int v);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (digit(v, i) == digit(v - 1, i));
    return r;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s at %0t: observed %b, expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state",   {2'b00, state},   4'(m_state));
    check("en_n",    en_n,             m_en_n);
    check("load",    {3'b000, load},   {3'b000, m_load});
    check("cnt_clr", {3'b000, cnt_clr}, {3'b000, m_clr});
    check("alarm",   {3'b000, alarm},  {3'b000, m_alarm});
    check("hi_nz",   hi_nz,            exp_hi_nz(cnt));
  endtask

  task automatic model_reset();
    m_state   = S_IDLE;
    m_k       = 0;
    m_en_n    = 4'hF;
    m_load    = 1'b0;
    m_clr     = 1'b0;
    m_alarm   = 1'b0;
    m_prev_st = 1'b1;
    m_prev_sp = 1'b1;
    m_prev_se = 1'b1;
  endtask

  // Advance one clock: the model and the counter chain consume what was on
  // the inputs at the edge, then nz is refreshed and every output compared.
  task automatic step();
    bit         ev_st;
    bit         ev_sp;
    bit         ev_se;
    int         nx;
    int         nk;
    int         ncnt;
    logic [3:0] nen;
    bit         nld;
    bit         ncl;
    @(posedge clk);
    #1;
    ev_st = start_btn && !m_prev_st;
    ev_sp = stop_btn  && !m_prev_sp;
    ev_se = set_btn   && !m_prev_se;
    nx  = m_state;
    nk  = m_k;
    nen = 4'hF;
    nld = 1'b0;
    ncl = 1'b0;
    case (m_state)
      S_IDLE: begin
        if (ev_se) nld = 1'b1;
        else if (ev_sp) ncl = 1'b1;
        else if (ev_st && cnt != 0) begin nx = S_RUN; nk = 0; end
      end
      S_RUN: begin
        if (cnt == 0) nx = S_DONE;
        else if (ev_sp) nx = S_PAUSE;
        else begin
          nk = m_k + 1;
          if (nk % TICK_DIV == TICK_DIV - 1) nen = exp_en_n(cnt);
        end
      end
      S_PAUSE: begin
        if (ev_se) begin nld = 1'b1; nx = S_IDLE; end
        else if (ev_sp) begin ncl = 1'b1; nx = S_IDLE; end
        else if (ev_st && cnt != 0) begin nx = S_RUN; nk = 0; end
      end
      default: begin
        if (ev_se) begin nld = 1'b1; nx = S_IDLE; end
        else if (ev_sp) nx = S_IDLE;
      end
    endcase
    // Counter chain reacts to the pulses that were present in the cycle just ended.
    ncnt = cnt;
    if (m_en_n != 4'hF) ncnt = cnt - 1;
    if (m_load) ncnt = preset;
    if (m_clr) ncnt = 0;

    m_state   = nx;
    m_k       = nk;
    m_en_n    = nen;
    m_load    = nld;
    m_clr     = ncl;
    m_alarm   = (nx == S_DONE);
    m_prev_st = start_btn;
    m_prev_sp = stop_btn;
    m_prev_se = set_btn;
    cnt       = ncnt;
    nz        = nz_of(cnt);
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic press(input bit st, input bit sp, input bit se);
    start_btn = st;
    stop_btn  = sp;
    set_btn   = se;
    step();
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    set_btn   = 1'b0;
  endtask

  // Pulse clear between clock edges and check the outputs before any edge arrives.
  task automatic async_reset();
    #2 clear = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 clear = 1'b1;
    #1 check_all();
    #5 clear = 1'b0;
    run_cycles(2);

    // Set in IDLE: one-cycle load, counter becomes 0001.
    preset = 1;
    press(0, 0, 1);
    check("load_pulse", {3'b000, load}, 4'd1);
    step();
    check("load_single", {3'b000, load}, 4'd0);

    // Start with a nonzero count; first tick in the 4th cycle of RUN.
    press(1, 0, 0);
    check("run_entry", {2'b00, state}, 4'd1);
    run_cycles(3);
    check("first_tick", en_n, 4'b1110);
    step();
    check("tick_one_cycle", en_n, 4'b1111);
    step();
    check("done_state", {2'b00, state}, 4'd3);
    check("done_alarm", {3'b000, alarm}, 4'd1);
    run_cycles(3);
    check("done_no_en", en_n, 4'b1111);
    press(0, 1, 0);
    check("done_stop_idle", {2'b00, state}, 4'd0);
    check("done_stop_alarm", {3'b000, alarm}, 4'd0);
    check("done_stop_noclr", {3'b000, cnt_clr}, 4'd0);

    // Borrow from 0120: the step to 0119 moves digits 0 and 1.
    preset = 120;
    press(0, 0, 1);
    step();
    press(1, 0, 0);
    run_cycles(3);
    check("borrow_0120_en", en_n, 4'b1100);
    check("borrow_0120_hi", hi_nz, 4'b0011);
    step();
    press(0, 0, 1);
    check("set_ignored_run", {2'b00, state}, 4'd1);
    check("set_ignored_load", {3'b000, load}, 4'd0);
    press(0, 1, 0);
    check("run_stop_pause", {2'b00, state}, 4'd2);

    // Set from PAUSE loads 1000; its tick enables every digit.
    preset = 1000;
    press(0, 0, 1);
    check("pause_set_idle", {2'b00, state}, 4'd0);
    step();
    press(1, 0, 0);
    run_cycles(3);
    check("borrow_1000_en", en_n, 4'b0000);
    // Reset in the middle of that tick.
    async_reset();
    check("rst_mid_run_en", en_n, 4'b1111);
    check("rst_mid_run_state", {2'b00, state}, 4'd0);

    // Pause at prescaler 2, resume, tick lands 4 cycles after resume.
    preset = 47;
    step();
    press(0, 0, 1);
    step();
    press(1, 0, 0);
    run_cycles(2);
    press(0, 1, 0);
    check("pause_entry", {2'b00, state}, 4'd2);
    check("pause_no_tick", en_n, 4'b1111);
    run_cycles(5);
    press(1, 0, 0);
    check("resume", {2'b00, state}, 4'd1);
    run_cycles(2);
    check("resume_no_early", en_n, 4'b1111);
    step();
    check("resume_tick", en_n, 4'b1110);
    press(0, 1, 0);
    step();
    press(0, 1, 0);
    check("pause_stop_clr", {3'b000, cnt_clr}, 4'd1);
    check("pause_stop_idle", {2'b00, state}, 4'd0);
    step();
    check("clr_single", {3'b000, cnt_clr}, 4'd0);

    // All three buttons together in PAUSE: only set acts.
    preset = 5;
    press(0, 0, 1);
    step();
    press(1, 0, 0);
    step();
    press(0, 1, 0);
    step();
    press(1, 1, 1);
    check("prio_load", {3'b000, load}, 4'd1);
    check("prio_noclr", {3'b000, cnt_clr}, 4'd0);
    check("prio_idle", {2'b00, state}, 4'd0);
    step();

    // Start held through reset release must not enter RUN.
    start_btn = 1'b1;
    async_reset();
    run_cycles(4);
    check("held_start_idle", {2'b00, state}, 4'd0);
    start_btn = 1'b0;
    step();
    press(1, 0, 0);
    check("fresh_start_run", {2'b00, state}, 4'd1);
    run_cycles(2);

    // Random button storm with varying presets and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      start_btn = ($urandom_range(0, 7) == 0);
      stop_btn  = ($urandom_range(0, 23) == 0);
      set_btn   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 9))
          0:       preset = 0;
          1:       preset = 1000;
          2:       preset = 120;
          3:       preset = 9;
          default: preset = int'($urandom_range(1, 40));
        endcase
      end
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    start_btn = 1'b0;
    stop_btn  = 1'b0;
    set_btn   = 1'b0;
    run_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
